// File: rtl/msg_streamer_if.sv
// Control and character-bus bundle for msg_streamer.
// The master side drives the control inputs and receives the character stream.
// The slave side is the streamer itself.
interface msg_streamer_if #(
    parameter int DATA_W = 8,
    parameter int IW     = 6,
    parameter int DIV_W  = 16
);
    logic              ena;
    logic              start;
    logic              stop;
    logic              loop_mode;
    logic              word_mode;
    logic              advance;
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [IW-1:0]     idx;
    logic              busy;
    logic              done;
    logic              wrap;

    modport master (
        output ena, start, stop, loop_mode, word_mode, advance, div,
        input  data_out, data_valid, idx, busy, done, wrap
    );

    modport slave (
        input  ena, start, stop, loop_mode, word_mode, advance, div,
        output data_out, data_valid, idx, busy, done, wrap
    );
endinterface

// File: rtl/msg_streamer.sv
// Replays a ROM-held character message onto a parallel bus at a programmable rate.
// Supports one-shot and loop modes, plus a word mode that pauses after each separator.
// All outputs are registered. ena=0 freezes all state and suppresses the strobes.
module msg_streamer #(
    parameter int                  DATA_W   = 8,
    parameter int                  DEPTH    = 64,
    parameter int                  MSG_LEN  = 51,
    parameter int                  DIV_W    = 16,
    parameter logic [DATA_W-1:0]   SEP      = 'h20,
    parameter logic [8*MSG_LEN-1:0] MSG_TEXT =
        "Tajumulco Tacana Acatenango Fuego Santa Maria Agua ",
    localparam int                 IW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    msg_streamer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t            state_reg, state_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [DIV_W-1:0]  counter_reg, counter_next;
    logic [DIV_W-1:0]  div_lat_reg, div_lat_next;
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic              data_valid_reg, data_valid_next;
    logic              done_reg, done_next;
    logic              wrap_reg, wrap_next;
    logic              busy_reg, busy_next;

    // Message ROM: first character of the text lands at index 0, unused entries are 0.
    logic [DATA_W-1:0] rom [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            if (gi < MSG_LEN) begin : g_used
                assign rom[gi] = DATA_W'(MSG_TEXT[8*(MSG_LEN-1-gi) +: 8]);
            end else begin : g_unused
                assign rom[gi] = '0;
            end
        end
    endgenerate

    // A tick emits one character; it only fires while running and the divider has expired.
    logic tick;
    logic last_char;
    logic is_sep;

    assign tick      = (state_reg == RUN) && (counter_reg == '0);
    assign last_char = (idx_reg == IW'(MSG_LEN - 1));
    assign is_sep    = (rom[idx_reg] == SEP);

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            counter_reg    <= '0;
            div_lat_reg    <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            wrap_reg       <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            counter_reg    <= counter_next;
            div_lat_reg    <= div_lat_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            done_reg       <= done_next;
            wrap_reg       <= wrap_next;
            busy_reg       <= busy_next;
        end
    end

    // Next-state decode; stop always beats start, and one-shot completion beats word pause.
    always_comb begin
        state_next = state_reg;
        if (bus.ena) begin
            case (state_reg)
                IDLE: begin
                    if (bus.start && !bus.stop) state_next = RUN;
                end
                RUN: begin
                    if (bus.stop)                            state_next = IDLE;
                    else if (tick && last_char && !bus.loop_mode) state_next = IDLE;
                    else if (tick && bus.word_mode && is_sep)     state_next = HOLD;
                end
                HOLD: begin
                    if (bus.stop)         state_next = IDLE;
                    else if (bus.advance) state_next = RUN;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath and strobe next values; strobes default low so they pulse for one cycle.
    always_comb begin
        idx_next        = idx_reg;
        counter_next    = counter_reg;
        div_lat_next    = div_lat_reg;
        data_out_next   = data_out_reg;
        data_valid_next = 1'b0;
        done_next       = 1'b0;
        wrap_next       = 1'b0;
        if (bus.ena) begin
            case (state_reg)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        idx_next     = '0;
                        counter_next = '0;
                        div_lat_next = bus.div;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        idx_next = '0;
                    end else if (tick) begin
                        data_out_next   = rom[idx_reg];
                        data_valid_next = 1'b1;
                        counter_next    = div_lat_reg;
                        if (last_char) begin
                            idx_next = '0;
                            if (bus.loop_mode) wrap_next = 1'b1;
                            else               done_next = 1'b1;
                        end else begin
                            idx_next = idx_reg + IW'(1);
                        end
                    end else begin
                        counter_next = counter_reg - DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.stop)         idx_next     = '0;
                    else if (bus.advance) counter_next = '0;
                end
                default: idx_next = '0;
            endcase
        end
        busy_next = (state_next != IDLE);
    end

    assign bus.data_out   = data_out_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.idx        = idx_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.wrap       = wrap_reg;

endmodule
